unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous byte RAM between the CPU instruction fetch port (i_*) and data port (d_*). Program and tape live in one physical memory.
- Sits between bfcpu and the board RAM primitive. It replaces separate instruction and data memories on boards with a single block RAM.
- Round-robin arbitration, one transaction in flight, req/ack handshake identical on both CPU-facing ports.

Parameters:
- MEM_AW, 11, RAM address width in bytes (2 KiB).
- D_BASE, 11'h700, RAM byte address of tape cell 0; d_addr is added to it. Must satisfy D_BASE + 255 < 2**MEM_AW.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  16  program byte address
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  8  fetched instruction byte, held until next i transaction
- d_req  in  1  data request; held with d_dir/d_addr/d_wdata stable until d_ack
- d_dir  in  1  `DIRECTION_WRITE = write, otherwise read
- d_addr  in  8  tape cell index
- d_wdata  in  8  write data
- d_ack  out  1  one-cycle pulse: access complete; d_rdata valid for reads
- d_rdata  out  8  read data, held until next d read
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  MEM_AW  RAM address (registered)
- mem_wdata  out  8  RAM write data (registered)
- mem_rdata  in  8  RAM read data, valid the cycle after the enabled edge

Behaviour:
- Reset: asynchronous, rst_n low. It forces state=IDLE, i_ack=d_ack=0, i_rdata=d_rdata=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, last_grant=I. A transaction in progress is abandoned. An interrupted write may or may not have reached RAM.
- FSM: IDLE -> ISSUE -> DATA -> COOL -> IDLE. One state per clock edge. There are no stalls.
- Edge E0, in IDLE, with any req high:
  - Choose the grant. If only one req is high, grant it. If both are high, grant the port not equal to last_grant.
  - Update last_grant.
  - Register mem_en, mem_we, mem_addr and mem_wdata. Go to ISSUE.
- IDLE with no req: mem_en=0, stay in IDLE.
- Address mapping:
  - i grant: mem_addr = i_addr[MEM_AW-1:0].
  - d grant: mem_addr = D_BASE + d_addr, computed in MEM_AW bits.
  - mem_we=1 only for a d write.
- Out-of-range fetch (i_addr >= D_BASE, including any nonzero bits at [15:MEM_AW]):
  - mem_en=0.
  - The returned byte is forced to 8'h00, which marks end of program.
  - Timing is the same as a normal fetch.
- E1 (ISSUE -> DATA): the RAM performs the access. mem_en and mem_we clear to 0 at E1.
- E2 (DATA -> COOL):
  - The granted port's rdata is loaded from mem_rdata (or 8'h00 for an out-of-range fetch). A d write does not change d_rdata.
  - The granted ack goes to 1.
- E3 (COOL -> IDLE): ack returns to 0. Reqs are not sampled in COOL.
- Requester rule: drop req at the first edge after ack is seen high, or keep it high with new operands for a back-to-back request. COOL guarantees a stale req is never sampled.
- Latency: req high before E0 gives ack high after E2, i.e. 3 cycles. Throughput is one transaction per 4 cycles. Under continuous contention, i and d alternate strictly.
- The acks are never high together, and the non-granted port's outputs are unchanged.
- A req that drops before being granted is simply not serviced. A req asserted during ISSUE/DATA/COOL waits for IDLE.
- d_addr = 8'hFF maps to D_BASE + 255. There is no wrap into program space.

Decomposition:
- State encodings (IDLE/ISSUE/DATA/COOL, 2-bit) and grant constants (GRANT_I=0, GRANT_D=1) go in macros/mem_arb.vh, alongside macros/direction.vh. Both are included by this block and its bench.
- Optional sub-module rr_arb2: a 2-input round-robin chooser with a last_grant register and an enable pulse from IDLE. All other logic stays in this module.

Test Plan:
- Reset release, i_req=1, i_addr=16'h0003, RAM[3]=8'h2B -> mem_en high for exactly one cycle with mem_addr=3. i_ack pulses 3 cycles after req; i_rdata=8'h2B.
- d write: d_dir=`DIRECTION_WRITE, d_addr=8'h05, d_wdata=8'hA5 -> mem_we=1 with mem_addr=11'h705. Then a d read of 8'h05 returns d_rdata=8'hA5, and i_rdata is unchanged.
- i_req and d_req held high together from reset for 4 transactions each -> grant order D,I,D,I,...; acks never overlap; each ack is 4 cycles apart.
- Out-of-range fetch: i_addr=16'h0700, then 16'h8000 -> mem_en stays 0; i_rdata=8'h00; i_ack pulses at normal latency.
- Boundary: d_addr=8'hFF write 8'h11 -> mem_addr=11'h7FF. A fetch from 11'h6FF still returns the program byte, not 8'h11.
- Reset mid-transaction: assert rst_n low during DATA -> all acks, mem_en and rdata are 0 immediately, asynchronously. After release, a pending d_req is granted first and completes normally.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2,
    ST_COOL  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_rr_arb2.sv
// Two-input round-robin chooser; the last grant is committed only while the
// enable (FSM in IDLE) is high and some request is present.
module unified_mem_arbiter_rr_arb2
  import unified_mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   i_req_i,
  input  logic   d_req_i,
  output grant_e grant_o
);

  grant_e last_q;

  always_comb begin
    grant_o = GRANT_I;
    if (i_req_i && d_req_i) begin
      grant_o = (last_q == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req_i) begin
      grant_o = GRANT_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GRANT_I;
    end else if (en_i && (i_req_i || d_req_i)) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port byte RAM between the instruction fetch and tape
// data ports; one transaction in flight, four cycles per transaction.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int                MEM_AW = 11,
  parameter logic [MEM_AW-1:0] D_BASE = 'h700
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [15:0]       i_addr,
  output logic              i_ack,
  output logic [7:0]        i_rdata,
  input  logic              d_req,
  input  logic              d_dir,
  input  logic [7:0]        d_addr,
  input  logic [7:0]        d_wdata,
  output logic              d_ack,
  output logic [7:0]        d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e            state_q;
  grant_e            gnt;
  grant_e            gnt_q;
  logic              oor_q;
  logic              dwr_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic [7:0]        i_rdata_q;
  logic [7:0]        d_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;

  // Anything at or above the tape base (including high address bits) is
  // outside program space and reads back as the end-of-program byte.
  logic              fetch_oor;
  logic [MEM_AW-1:0] d_mem_addr;
  logic              d_is_write;

  assign fetch_oor  = (i_addr >= 16'(D_BASE));
  assign d_mem_addr = D_BASE + MEM_AW'(d_addr);
  assign d_is_write = (d_dir == DIR_WRITE);

  unified_mem_arbiter_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (state_q == ST_IDLE),
    .i_req_i (i_req),
    .d_req_i (d_req),
    .grant_o (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GRANT_I;
      oor_q       <= 1'b0;
      dwr_q       <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= 8'h00;
      d_rdata_q   <= 8'h00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req || d_req) begin
            gnt_q   <= gnt;
            state_q <= ST_ISSUE;
            if (gnt == GRANT_D) begin
              mem_en_q    <= 1'b1;
              mem_we_q    <= d_is_write;
              mem_addr_q  <= d_mem_addr;
              mem_wdata_q <= d_wdata;
              dwr_q       <= d_is_write;
              oor_q       <= 1'b0;
            end else begin
              mem_en_q    <= ~fetch_oor;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= i_addr[MEM_AW-1:0];
              mem_wdata_q <= 8'h00;
              dwr_q       <= 1'b0;
              oor_q       <= fetch_oor;
            end
          end else begin
            mem_en_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= ST_DATA;
        end
        ST_DATA: begin
          if (gnt_q == GRANT_I) begin
            i_rdata_q <= oor_q ? 8'h00 : mem_rdata;
            i_ack_q   <= 1'b1;
          end else begin
            if (!dwr_q) begin
              d_rdata_q <= mem_rdata;
            end
            d_ack_q <= 1'b1;
          end
          state_q <= ST_COOL;
        end
        ST_COOL: begin
          // Requests are deliberately not sampled here, so a req still high
          // from the just-acked transaction is never mistaken for a new one.
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
